// File: rtl/clock_pkg.sv
// clock_pkg: field, op and state encodings shared by time_update_scheduler (TUS_DAY_CLAMP_EN adds the clamp states)
package clock_pkg;
  typedef enum logic [2:0] {F_SEC, F_MIN, F_HOUR, F_DAY, F_MONTH, F_YEAR} field_e;
  typedef enum logic [1:0] {OP_INC = 2'b00, OP_DEC = 2'b01, OP_CLAMP = 2'b10} op_e;
  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
`ifdef TUS_DAY_CLAMP_EN
    , S_CLAMP_ISSUE,
    S_CLAMP_WAIT
`endif
  } state_e;
  localparam logic [2:0] FIELD_MAX = F_YEAR;
  function automatic logic clamps_day(input logic [2:0] f);
    return f == F_MONTH || f == F_YEAR;
  endfunction
endpackage

// File: rtl/time_update_scheduler_if.sv
// time_update_scheduler_if: command/response bus between the scheduler and the counter bank
interface time_update_scheduler_if;
  logic       cmd_valid;
  logic [2:0] cmd_field;
  logic [1:0] cmd_op;
  logic       cmd_ready;
  logic       rsp_valid;
  logic       rsp_wrap;
  modport master (output cmd_valid, cmd_field, cmd_op, input cmd_ready, rsp_valid, rsp_wrap);
  modport slave (input cmd_valid, cmd_field, cmd_op, output cmd_ready, rsp_valid, rsp_wrap);
endinterface

// File: rtl/time_update_scheduler.sv
// time_update_scheduler: turns 1 Hz ticks (with carry chains) and manual edits into counter-bank commands
// Define TUS_DAY_CLAMP_EN to follow every MONTH/YEAR command with a CLAMP of DAY.
module time_update_scheduler
  import clock_pkg::*;
#(
  parameter int CHAIN_TOP = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            tick_1hz,
  input  logic                            man_req,
  input  logic [2:0]                      man_field,
  input  logic                            man_dir,
  time_update_scheduler_if.master         bus,
  output logic                            busy,
  output logic                            man_drop,
  output logic                            tick_lost
);
  localparam logic [2:0] TOP = 3'(CHAIN_TOP);
  state_e     state;
  logic       tick_pend, man_pend, man_pend_dir, cur_man;
  logic [2:0] man_pend_field, cur_field, sel_field;
  logic       man_ok, drop, idle, sel_man, sel_dir, take_tick, carry;
  assign busy = state != S_IDLE;
  // in IDLE a fresh request is served directly, as if it had been latched and selected at once
  always_comb begin
    man_ok    = man_req && !man_pend && man_field <= FIELD_MAX;
    drop      = man_req && !man_ok;
    idle      = state == S_IDLE;
    sel_man   = man_pend || man_ok;
    sel_field = man_pend ? man_pend_field : man_field;
    sel_dir   = man_pend ? man_pend_dir : man_dir;
    take_tick = idle && !sel_man && (tick_pend || tick_1hz);
    carry     = !cur_man && bus.rsp_wrap && cur_field < TOP;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      tick_pend      <= 1'b0;
      man_pend       <= 1'b0;
      man_pend_field <= 3'd0;
      man_pend_dir   <= 1'b0;
      tick_lost      <= 1'b0;
      man_drop       <= 1'b0;
      cur_field      <= 3'd0;
      cur_man        <= 1'b0;
      bus.cmd_valid  <= 1'b0;
      bus.cmd_field  <= 3'd0;
      bus.cmd_op     <= 2'd0;
    end else begin
      man_drop  <= drop;
      tick_pend <= take_tick ? (tick_pend && tick_1hz) : (tick_pend || tick_1hz);
      tick_lost <= tick_lost || (tick_1hz && tick_pend && !take_tick);
      if (idle) man_pend <= 1'b0;
      else if (man_ok) {man_pend, man_pend_field, man_pend_dir} <= {1'b1, man_field, man_dir};
      case (state)
        S_IDLE: if (sel_man || take_tick) begin
          state         <= S_ISSUE;
          bus.cmd_valid <= 1'b1;
          bus.cmd_field <= sel_man ? sel_field : F_SEC;
          bus.cmd_op    <= (sel_man && sel_dir) ? OP_DEC : OP_INC;
          cur_field     <= sel_man ? sel_field : F_SEC;
          cur_man       <= sel_man;
        end
        S_ISSUE: if (bus.cmd_ready) begin
          state         <= S_WAIT;
          bus.cmd_valid <= 1'b0;
          bus.cmd_field <= 3'd0;
          bus.cmd_op    <= 2'd0;
        end
        S_WAIT: if (bus.rsp_valid) begin
          if (carry) begin
            state         <= S_ISSUE;
            bus.cmd_valid <= 1'b1;
            bus.cmd_field <= cur_field + 3'd1;
            bus.cmd_op    <= OP_INC;
            cur_field     <= cur_field + 3'd1;
          end
`ifdef TUS_DAY_CLAMP_EN
          else if (clamps_day(cur_field)) begin
            state         <= S_CLAMP_ISSUE;
            bus.cmd_valid <= 1'b1;
            bus.cmd_field <= F_DAY;
            bus.cmd_op    <= OP_CLAMP;
          end
`endif
          else state <= S_IDLE;
        end
`ifdef TUS_DAY_CLAMP_EN
        S_CLAMP_ISSUE: if (bus.cmd_ready) begin
          state         <= S_CLAMP_WAIT;
          bus.cmd_valid <= 1'b0;
          bus.cmd_field <= 3'd0;
          bus.cmd_op    <= 2'd0;
        end
        S_CLAMP_WAIT: if (bus.rsp_valid) state <= S_IDLE;
`endif
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_time_update_scheduler.sv
// tb_time_update_scheduler: randomized bank responder plus a command-sequence model of ticks and manual edits
module tb_time_update_scheduler;
  localparam int CHAIN_TOP = 5;
  logic clk = 1'b0, rst, tick_1hz, man_req, man_dir, busy, man_drop, tick_lost;
  logic [2:0] man_field;
  logic [7:0] wrap_mask;
  logic [2:0] acc_field;
  bit hold, slow;
  int rsp_cnt = 0, checks = 0, errors = 0;
  logic [4:0] obs[$], exp[$];
  time_update_scheduler_if bus ();
  time_update_scheduler #(.CHAIN_TOP(CHAIN_TOP)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .man_req(man_req), .man_field(man_field),
    .man_dir(man_dir), .bus(bus), .busy(busy), .man_drop(man_drop), .tick_lost(tick_lost)
  );
  always #5 clk = ~clk;
  // counter bank: random ready, random response latency, wrap taken from the per-field mask
  always @(negedge clk) begin
    bus.rsp_valid = 1'b0;
    bus.rsp_wrap  = 1'b0;
    if (rst) rsp_cnt = 0;
    else if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        bus.rsp_valid = 1'b1;
        bus.rsp_wrap  = wrap_mask[acc_field];
      end
    end
    checks++;
    if (!bus.cmd_valid && (bus.cmd_field !== 3'd0 || bus.cmd_op !== 2'd0)) begin
      errors++;
      $display("FAIL idle_cmd_zero got field %0d op %0d want 0 0", bus.cmd_field, bus.cmd_op);
    end
    bus.cmd_ready = !hold && $urandom_range(0, 2) != 0;
    if (!rst && bus.cmd_valid && bus.cmd_ready) begin
      obs.push_back({bus.cmd_field, bus.cmd_op});
      acc_field = bus.cmd_field;
      rsp_cnt = slow ? 20 : int'($urandom_range(1, 4));
    end
  end
  task automatic model_clamp(input int f);
`ifdef TUS_DAY_CLAMP_EN
    if (f == 4 || f == 5) exp.push_back({3'd3, 2'b10});
`endif
  endtask
  task automatic model_tick(input logic [7:0] mask);
    int f = 0;
    exp.push_back({3'd0, 2'b00});
    while (f < CHAIN_TOP && mask[f]) begin
      f++;
      exp.push_back({3'(f), 2'b00});
    end
    model_clamp(f);
  endtask
  task automatic model_man(input int f, input bit d);
    exp.push_back({3'(f), d ? 2'b01 : 2'b00});
    model_clamp(f);
  endtask
  task automatic pulse(input bit t, input bit m, input logic [2:0] f, input bit d);
    @(negedge clk);
    tick_1hz = t; man_req = m; man_field = f; man_dir = d;
    @(negedge clk);
    tick_1hz = 1'b0; man_req = 1'b0;
  endtask
  task automatic wait_quiet(output bit ok);
    int q = 0;
    ok = 1'b0;
    for (int c = 0; c < 600 && !ok; c++) begin
      @(negedge clk);
      q = (!busy && rsp_cnt == 0) ? q + 1 : 0;
      ok = q >= 4;
    end
  endtask
  task automatic test_reset;
    bit ok;
    rst = 1'b1;
    tick_1hz = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, bus.cmd_valid, bus.cmd_field, bus.cmd_op, man_drop, tick_lost} !== 9'd0) begin
      errors++;
      $display("FAIL reset_state got %b want 0", {busy, bus.cmd_valid, bus.cmd_field, bus.cmd_op, man_drop, tick_lost});
    end
    tick_1hz = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, bus.cmd_valid, man_drop, tick_lost} !== 4'd0) begin
      errors++;
      $display("FAIL post_reset got %b want 0", {busy, bus.cmd_valid, man_drop, tick_lost});
    end
    wait_quiet(ok);
    checks++;
    if (!ok || obs.size() != 0) begin
      errors++;
      $display("FAIL reset_no_cmd got %0d cmds ok %0d want 0 cmds ok 1", obs.size(), ok);
    end
    obs.delete();
  endtask
  task automatic test_sec_wrap;
    bit ok;
    wrap_mask = 8'h01;
    model_tick(wrap_mask);
    pulse(1, 0, 0, 0);
    wait_quiet(ok);
    checks++;
    if (!ok || obs.size() != exp.size()) begin
      errors++;
      $display("FAIL sec_wrap count got %0d want %0d (ok %0d)", obs.size(), exp.size(), ok);
    end
    foreach (exp[i]) if (i < obs.size()) begin
      checks++;
      if (obs[i] !== exp[i]) begin errors++; $display("FAIL sec_wrap cmd%0d got %h want %h", i, obs[i], exp[i]); end
    end
    obs.delete(); exp.delete();
  endtask
  task automatic test_full_carry;
    bit ok;
    wrap_mask = 8'hff;
    model_tick(wrap_mask);
    pulse(1, 0, 0, 0);
    wait_quiet(ok);
    checks++;
    if (!ok || obs.size() != exp.size()) begin
      errors++;
      $display("FAIL full_carry count got %0d want %0d (ok %0d)", obs.size(), exp.size(), ok);
    end
    foreach (exp[i]) if (i < obs.size()) begin
      checks++;
      if (obs[i] !== exp[i]) begin errors++; $display("FAIL full_carry cmd%0d got %h want %h", i, obs[i], exp[i]); end
    end
    obs.delete(); exp.delete();
  endtask
  task automatic test_coincident;
    bit ok;
    wrap_mask = 8'h00;
    model_man(4, 1);
    model_tick(wrap_mask);
    pulse(1, 1, 3'd4, 1);
    wait_quiet(ok);
    checks++;
    if (!ok || obs.size() != exp.size()) begin
      errors++;
      $display("FAIL coincident count got %0d want %0d (ok %0d)", obs.size(), exp.size(), ok);
    end
    foreach (exp[i]) if (i < obs.size()) begin
      checks++;
      if (obs[i] !== exp[i]) begin errors++; $display("FAIL coincident cmd%0d got %h want %h", i, obs[i], exp[i]); end
    end
    obs.delete(); exp.delete();
  endtask
  task automatic test_tick_lost;
    bit ok;
    wrap_mask = 8'h00;
    hold = 1'b1;
    pulse(1, 0, 0, 0);
    checks++;
    if ({bus.cmd_valid, bus.cmd_field, bus.cmd_op} !== 6'b1_000_00) begin
      errors++;
      $display("FAIL held_cmd got %b want 100000", {bus.cmd_valid, bus.cmd_field, bus.cmd_op});
    end
    pulse(1, 0, 0, 0);
    checks++;
    if (tick_lost !== 1'b0) begin errors++; $display("FAIL first_latch_lost got %b want 0", tick_lost); end
    pulse(1, 0, 0, 0);
    checks++;
    if (tick_lost !== 1'b1) begin errors++; $display("FAIL second_tick_lost got %b want 1", tick_lost); end
    repeat (5) @(negedge clk);
    checks++;
    if ({bus.cmd_valid, bus.cmd_field, bus.cmd_op} !== 6'b1_000_00) begin
      errors++;
      $display("FAIL held_stable got %b want 100000", {bus.cmd_valid, bus.cmd_field, bus.cmd_op});
    end
    hold = 1'b0;
    model_tick(wrap_mask);
    model_tick(wrap_mask);
    wait_quiet(ok);
    checks++;
    if (!ok || obs.size() != exp.size()) begin
      errors++;
      $display("FAIL tick_lost count got %0d want %0d (ok %0d)", obs.size(), exp.size(), ok);
    end
    foreach (exp[i]) if (i < obs.size()) begin
      checks++;
      if (obs[i] !== exp[i]) begin errors++; $display("FAIL tick_lost cmd%0d got %h want %h", i, obs[i], exp[i]); end
    end
    obs.delete(); exp.delete();
    checks++;
    if (tick_lost !== 1'b1) begin errors++; $display("FAIL lost_sticky got %b want 1", tick_lost); end
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    checks++;
    if (tick_lost !== 1'b0) begin errors++; $display("FAIL lost_cleared got %b want 0", tick_lost); end
  endtask
  task automatic test_man_drop;
    bit ok;
    wrap_mask = 8'hff;
    pulse(0, 1, 3'd6, 0);
    checks++;
    if (man_drop !== 1'b1) begin errors++; $display("FAIL bad_field_drop got %b want 1", man_drop); end
    @(negedge clk);
    checks++;
    if (man_drop !== 1'b0) begin errors++; $display("FAIL bad_field_once got %b want 0", man_drop); end
    wait_quiet(ok);
    checks++;
    if (!ok || obs.size() != 0) begin
      errors++;
      $display("FAIL bad_field_cmds got %0d want 0 (ok %0d)", obs.size(), ok);
    end
    obs.delete();
    hold = 1'b1;
    pulse(0, 1, 3'd1, 0);
    pulse(0, 1, 3'd2, 1);
    checks++;
    if (man_drop !== 1'b0) begin errors++; $display("FAIL pend_accept got %b want 0", man_drop); end
    pulse(0, 1, 3'd3, 0);
    checks++;
    if (man_drop !== 1'b1) begin errors++; $display("FAIL pend_full_drop got %b want 1", man_drop); end
    @(negedge clk);
    checks++;
    if (man_drop !== 1'b0) begin errors++; $display("FAIL pend_full_once got %b want 0", man_drop); end
    hold = 1'b0;
    model_man(1, 0);
    model_man(2, 1);
    wait_quiet(ok);
    checks++;
    if (!ok || obs.size() != exp.size()) begin
      errors++;
      $display("FAIL man_pend count got %0d want %0d (ok %0d)", obs.size(), exp.size(), ok);
    end
    foreach (exp[i]) if (i < obs.size()) begin
      checks++;
      if (obs[i] !== exp[i]) begin errors++; $display("FAIL man_pend cmd%0d got %h want %h", i, obs[i], exp[i]); end
    end
    obs.delete(); exp.delete();
  endtask
  task automatic test_reset_mid;
    bit ok;
    wrap_mask = 8'h03;
    slow = 1'b1;
    pulse(1, 0, 0, 0);
    for (int c = 0; c < 300 && obs.size() < 2; c++) @(negedge clk);
    checks++;
    if (obs.size() != 2) begin errors++; $display("FAIL mid_reach_min got %0d cmds want 2", obs.size()); end
    pulse(1, 1, 3'd2, 0);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, bus.cmd_valid, bus.cmd_field, bus.cmd_op} !== 7'd0) begin
      errors++;
      $display("FAIL mid_reset_idle got %b want 0", {busy, bus.cmd_valid, bus.cmd_field, bus.cmd_op});
    end
    rst = 1'b0;
    slow = 1'b0;
    wait_quiet(ok);
    exp.push_back({3'd0, 2'b00});
    exp.push_back({3'd1, 2'b00});
    checks++;
    if (!ok || obs.size() != exp.size()) begin
      errors++;
      $display("FAIL mid_reset count got %0d want %0d (ok %0d)", obs.size(), exp.size(), ok);
    end
    foreach (exp[i]) if (i < obs.size()) begin
      checks++;
      if (obs[i] !== exp[i]) begin errors++; $display("FAIL mid_reset cmd%0d got %h want %h", i, obs[i], exp[i]); end
    end
    obs.delete(); exp.delete();
  endtask
  task automatic test_random;
    bit ok;
    for (int n = 0; n < 30; n++) begin
      int mode = int'($urandom_range(0, 2));
      int f = int'($urandom_range(0, 5));
      bit d = 1'($urandom_range(0, 1));
      wrap_mask = 8'($urandom);
      if (mode != 0) model_man(f, d);
      if (mode != 1) model_tick(wrap_mask);
      pulse(mode != 1, mode != 0, 3'(f), d);
      wait_quiet(ok);
      checks++;
      if (!ok || obs.size() != exp.size()) begin
        errors++;
        $display("FAIL random%0d count got %0d want %0d (ok %0d)", n, obs.size(), exp.size(), ok);
      end
      foreach (exp[i]) if (i < obs.size()) begin
        checks++;
        if (obs[i] !== exp[i]) begin errors++; $display("FAIL random%0d cmd%0d got %h want %h", n, i, obs[i], exp[i]); end
      end
      obs.delete(); exp.delete();
    end
  endtask
  initial begin
    rst = 1'b1; tick_1hz = 1'b0; man_req = 1'b0; man_field = 3'd0; man_dir = 1'b0;
    hold = 1'b0; slow = 1'b0; wrap_mask = 8'h00; acc_field = 3'd0;
    test_reset();
    test_sec_wrap();
    test_full_carry();
    test_coincident();
    test_tick_lost();
    test_man_drop();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/time_update_scheduler.md
TIME_UPDATE_SCHEDULER -- requirements
Module: time_update_scheduler

Interface
REQ-001 SHALL have parameter CHAIN_TOP, default 5, meaning the highest field index reached by automatic carry propagation (5 = YEAR).
REQ-002 SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port tick_1hz  input  1  one-cycle pulse requesting one automatic second increment.
REQ-005 SHALL have port man_req  input  1  one-cycle pulse from the setting controller requesting one manual edit.
REQ-006 SHALL have port man_field  input  3  field of the manual edit: SEC=0, MIN=1, HOUR=2, DAY=3, MONTH=4, YEAR=5.
REQ-007 SHALL have port man_dir  input  1  direction of the manual edit: 0 = up, 1 = down.
REQ-008 SHALL have port cmd_valid  output  1  command to the counter bank is valid.
REQ-009 SHALL have port cmd_field  output  3  target field of the command.
REQ-010 SHALL have port cmd_op  output  2  command operation: INC=00, DEC=01, CLAMP=10.
REQ-011 SHALL have port cmd_ready  input  1  counter bank accepts the command this cycle.
REQ-012 SHALL have port rsp_valid  input  1  counter bank has completed the accepted command.
REQ-013 SHALL have port rsp_wrap  input  1  completed command wrapped: max->min on INC, min->max on DEC; qualified by rsp_valid.
REQ-014 SHALL have port busy  output  1  the state machine is not in IDLE.
REQ-015 SHALL have port man_drop  output  1  one-cycle pulse when a manual request is discarded.
REQ-016 SHALL have port tick_lost  output  1  sticky flag set when a tick is discarded; cleared only by rst.

Function
REQ-017 SHALL implement states IDLE, ISSUE, WAIT, CLAMP_ISSUE and CLAMP_WAIT.
REQ-018 SHALL hold a one-deep tick-pending flag and a one-deep manual-pending entry {field, dir}.
- Each is set on the cycle its request is sampled.
REQ-019 SHALL, in IDLE, select the manual entry if pending, else the tick, and enter ISSUE on the next edge.
- cmd_valid asserts in the cycle after the request is sampled.
- The pending entry clears on selection.
REQ-020 SHALL, in ISSUE, hold cmd_valid, cmd_field and cmd_op stable until cmd_ready is high, then enter WAIT.
REQ-021 SHALL, for a tick, issue INC to SEC.
- In WAIT, on rsp_valid with rsp_wrap=1 and field < CHAIN_TOP: issue INC to field+1 (back to ISSUE).
- Otherwise the chain ends.
REQ-022 SHALL, for a manual edit, issue a single INC (dir=0) or DEC (dir=1) to man_field, never propagating carry or borrow regardless of rsp_wrap.
REQ-023 SHALL return to IDLE when the chain or edit ends, except as stated in REQ-031.
REQ-024 SHALL latch a tick arriving during any non-IDLE state into tick-pending.
- If tick-pending is already set, the tick SHALL be discarded and tick_lost set.
REQ-025 SHALL discard a man_req that arrives while manual-pending is set, or that carries man_field > 5, and pulse man_drop in the following cycle.
REQ-026 SHALL, when tick_1hz and man_req coincide in IDLE, latch both and serve the manual edit first.
REQ-027 SHALL ignore rsp_valid outside WAIT and CLAMP_WAIT, and ignore cmd_ready while cmd_valid=0.
REQ-028 SHALL assert cmd_valid only in ISSUE and CLAMP_ISSUE; cmd_field and cmd_op SHALL be 0 when cmd_valid=0.

Reset
REQ-029 SHALL, while rst=1, force IDLE and clear both pending entries, tick_lost, man_drop, cmd_valid, cmd_field and cmd_op; busy reads 0.
REQ-030 SHALL abandon any in-flight chain or edit on rst without issuing further commands; outputs are valid from the first cycle after rst deasserts.

Configuration
REQ-031 SHALL, with macro TUS_DAY_CLAMP_EN defined, follow every completed command to MONTH or YEAR (auto or manual) with CLAMP_ISSUE/CLAMP_WAIT issuing one CLAMP to DAY, then return to IDLE.
- A tick chain that continues past MONTH clamps only after the chain ends.
REQ-032 SHALL, without TUS_DAY_CLAMP_EN, omit CLAMP_ISSUE and CLAMP_WAIT and never emit op CLAMP.

Structure
REQ-033 SHALL take field codes (SEC..YEAR), op codes (INC, DEC, CLAMP) and the state encoding from a shared package, clock_pkg.
REQ-034 SHALL be a single module with no sub-modules; the pending-request latch and select logic stay inline.

Verification
REQ-035 Tick with bank showing sec wrap only -> commands INC SEC, INC MIN; busy falls after the second rsp_valid.
REQ-036 Tick at 23:59:59 on 31 Dec with rsp_wrap=1 on every field -> six INCs, SEC through YEAR, then IDLE.
- With TUS_DAY_CLAMP_EN: one CLAMP DAY follows the YEAR INC.
REQ-037 Same-cycle tick and man_req{field=4, dir=1} in IDLE -> DEC MONTH issued first, then INC SEC.
- With TUS_DAY_CLAMP_EN: CLAMP DAY sits between them.
REQ-038 Two ticks during a held-off chain (cmd_ready=0 for 10 cycles) -> first tick latched, second discarded, tick_lost=1 until rst.
REQ-039 man_req with field=6 -> no command issued; man_drop pulses once.
- Second man_req while one is pending -> man_drop pulses.
REQ-040 rst=1 for one cycle during WAIT of a MIN INC -> next cycle IDLE, cmd_valid=0, pending entries cleared, no HOUR command issued.
